// File: rtl/isr_tracker_if.sv
// Z80 bus bundle shared between the bus driver and the ISR tracker.
// The master drives the bus controls and context bits. The slave returns
// the instruction-boundary qualifiers and the I/O policing results.
interface isr_tracker_if;
  logic        m1_n;
  logic        mreq_n;
  logic        iorq_n;
  logic        rd_n;
  logic        wr_n;
  logic [7:0]  addr;
  logic [7:0]  data;
  logic        trap_state;
  logic        virtual_enabled;
  logic        new_isr;
  logic        last_isr_jmp;
  logic        io_trap_condition;
  logic [7:0]  trap_port;
  logic        trap_dir;
  logic [15:0] permit_mask;

  modport master (
    output m1_n, mreq_n, iorq_n, rd_n, wr_n, addr, data,
           trap_state, virtual_enabled,
    input  new_isr, last_isr_jmp, io_trap_condition, trap_port,
           trap_dir, permit_mask
  );

  modport slave (
    input  m1_n, mreq_n, iorq_n, rd_n, wr_n, addr, data,
           trap_state, virtual_enabled,
    output new_isr, last_isr_jmp, io_trap_condition, trap_port,
           trap_dir, permit_mask
  );
endinterface

// File: rtl/isr_tracker.sv
// Z80 instruction-boundary tracker and guest I/O policer.
// It follows opcode fetches through CB/ED/DD/FD prefixes so the trap
// controller knows when the next M1 starts a new instruction, and whether
// the last instruction was an absolute jump. Guest I/O is checked against a
// 16-bit port-group permit mask. The mask is loadable only from handler
// context.
module isr_tracker #(
  parameter logic [7:0]  CFG_PORT     = 8'h3E,
  parameter logic [15:0] PERMIT_RESET = 16'h0000
) (
  input logic          clk,
  input logic          rst,
  isr_tracker_if.slave bus
);

  localparam logic [7:0] CFG_PORT_HI = CFG_PORT + 8'd1;

  typedef enum logic [1:0] {
    ST_START  = 2'd0,
    ST_PFX_CB = 2'd1,
    ST_PFX_ED = 2'd2,
    ST_PFX_IX = 2'd3
  } state_t;

  state_t      r_state;
  logic [7:0]  r_op;
  logic        r_m1Prev;
  logic        r_fetchSeen;
  logic        r_iorqPrev;
  logic        r_newIsr;
  logic        r_lastIsrJmp;
  logic        r_ioTrap;
  logic [7:0]  r_trapPort;
  logic        r_trapDir;
  logic [15:0] r_permitMask;

  logic w_fetchClk;
  logic w_fetchEnd;
  logic w_ioClk;
  logic w_ioFirst;
  logic w_violation;

  // An interrupt acknowledge never asserts mreq_n/rd_n together with m1_n,
  // so it can never count as a fetch. Such an M1 passes through without
  // disturbing the decoder.
  assign w_fetchClk  = !bus.m1_n && !bus.mreq_n && !bus.rd_n;
  assign w_fetchEnd  = !r_m1Prev && bus.m1_n && r_fetchSeen;
  assign w_ioClk     = !bus.iorq_n && bus.m1_n && (!bus.rd_n || !bus.wr_n);
  assign w_ioFirst   = w_ioClk && r_iorqPrev;
  assign w_violation = w_ioClk && !bus.trap_state && bus.virtual_enabled &&
                       !r_permitMask[bus.addr[7:4]];

  // Bus history: previous M1/IORQ levels, the opcode byte, and whether this M1 fetched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m1Prev    <= 1'b1;
      r_iorqPrev  <= 1'b1;
      r_fetchSeen <= 1'b0;
      r_op        <= 8'h00;
    end else begin
      r_m1Prev   <= bus.m1_n;
      r_iorqPrev <= bus.iorq_n;
      if (w_fetchClk) begin
        r_op        <= bus.data;
        r_fetchSeen <= 1'b1;
      end else if (bus.m1_n) begin
        r_fetchSeen <= 1'b0;
      end
    end
  end

  // Prefix decoder FSM; new_isr and last_isr_jmp are registered alongside the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_START;
      r_newIsr     <= 1'b1;
      r_lastIsrJmp <= 1'b0;
    end else if (w_fetchEnd) begin
      case (r_state)
        ST_START: begin
          case (r_op)
            8'hCB: begin
              r_state  <= ST_PFX_CB;
              r_newIsr <= 1'b0;
            end
            8'hED: begin
              r_state  <= ST_PFX_ED;
              r_newIsr <= 1'b0;
            end
            8'hDD, 8'hFD: begin
              r_state  <= ST_PFX_IX;
              r_newIsr <= 1'b0;
            end
            default: begin
              r_state      <= ST_START;
              r_newIsr     <= 1'b1;
              r_lastIsrJmp <= (r_op == 8'hC3) || (r_op == 8'hE9);
            end
          endcase
        end
        ST_PFX_CB, ST_PFX_ED: begin
          r_state      <= ST_START;
          r_newIsr     <= 1'b1;
          r_lastIsrJmp <= 1'b0;
        end
        ST_PFX_IX: begin
          // A repeated index prefix replaces the earlier one. DDCB finishes
          // here because its displacement and opcode arrive as plain reads.
          if (r_op == 8'hDD || r_op == 8'hFD) begin
            r_state  <= ST_PFX_IX;
            r_newIsr <= 1'b0;
          end else begin
            r_state      <= ST_START;
            r_newIsr     <= 1'b1;
            r_lastIsrJmp <= (r_op == 8'hE9);
          end
        end
        default: begin
          r_state  <= ST_START;
          r_newIsr <= 1'b1;
        end
      endcase
    end
  end

  // Sticky violation flag and first-offender latch; handler context clears it first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ioTrap   <= 1'b0;
      r_trapPort <= 8'h00;
      r_trapDir  <= 1'b0;
    end else if (bus.trap_state) begin
      r_ioTrap <= 1'b0;
    end else if (w_violation && !r_ioTrap) begin
      r_ioTrap   <= 1'b1;
      r_trapPort <= bus.addr;
      r_trapDir  <= !bus.wr_n;
    end
  end

  // Permit mask load from handler context, acting only on the first clock of the I/O cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_permitMask <= PERMIT_RESET;
    end else if (w_ioFirst && !bus.wr_n && bus.trap_state) begin
      if (bus.addr == CFG_PORT) begin
        r_permitMask[7:0] <= bus.data;
      end else if (bus.addr == CFG_PORT_HI) begin
        r_permitMask[15:8] <= bus.data;
      end
    end
  end

  assign bus.new_isr           = r_newIsr;
  assign bus.last_isr_jmp      = r_lastIsrJmp;
  assign bus.io_trap_condition = r_ioTrap;
  assign bus.trap_port         = r_trapPort;
  assign bus.trap_dir          = r_trapDir;
  assign bus.permit_mask       = r_permitMask;

endmodule

// File: tb/tb_isr_tracker.sv
// Directed bench for isr_tracker. It drives Z80-style fetch, interrupt
// acknowledge and I/O cycles, then compares the outputs with hand-derived
// values.
module tb_isr_tracker;

  logic clk;
  logic rst;
  int   totalChecks;
  int   badChecks;

  isr_tracker_if bus ();

  isr_tracker dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 100 MHz-style free-running clock; the DUT samples on the rising edge
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it if the observed value is wrong
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drive one clock of bus controls (from a falling edge) and wait for the next falling edge
  task automatic applyStimulus(input logic m1, input logic mreq, input logic iorq,
                               input logic rd, input logic wr,
                               input logic [7:0] a, input logic [7:0] d);
    bus.m1_n   = m1;
    bus.mreq_n = mreq;
    bus.iorq_n = iorq;
    bus.rd_n   = rd;
    bus.wr_n   = wr;
    bus.addr   = a;
    bus.data   = d;
    @(negedge clk);
  endtask

  // Idle bus clock
  task automatic idleClk();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00);
  endtask

  // Opcode fetch M1: two fetch clocks, then a refresh clock on which m1_n is high
  task automatic fetch(input logic [7:0] op);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, op);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, op);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00);
  endtask

  // Non-M1 memory read clock (DDCB displacement/opcode bytes)
  task automatic memRead(input logic [7:0] d);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, d);
    idleClk();
  endtask

  // Complete I/O cycle with the given number of wait states, then an idle clock
  task automatic ioCycle(input logic [7:0] port, input logic [7:0] d,
                         input logic isWrite, input int waits);
    for (int i = 0; i <= waits; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, isWrite, !isWrite, port, d);
    end
    idleClk();
  endtask

  initial begin
    totalChecks = 0;
    badChecks   = 0;
    rst = 1'b1;
    bus.trap_state      = 1'b0;
    bus.virtual_enabled = 1'b0;
    bus.m1_n   = 1'b1;
    bus.mreq_n = 1'b1;
    bus.iorq_n = 1'b1;
    bus.rd_n   = 1'b1;
    bus.wr_n   = 1'b1;
    bus.addr   = 8'h00;
    bus.data   = 8'h00;
    @(negedge clk);
    @(negedge clk);

    checkOutput("rst_new_isr", bus.new_isr, 1);
    checkOutput("rst_jmp", bus.last_isr_jmp, 0);
    checkOutput("rst_flag", bus.io_trap_condition, 0);
    checkOutput("rst_port", bus.trap_port, 0);
    checkOutput("rst_dir", bus.trap_dir, 0);
    checkOutput("rst_mask", bus.permit_mask, 16'h0000);
    rst = 1'b0;
    idleClk();

    // Plain fetch sequence through an index prefix
    fetch(8'h00);
    checkOutput("seq00_new", bus.new_isr, 1);
    checkOutput("seq00_jmp", bus.last_isr_jmp, 0);
    fetch(8'hDD);
    checkOutput("seqDD_new", bus.new_isr, 0);
    checkOutput("seqDD_jmp", bus.last_isr_jmp, 0);
    fetch(8'h21);
    checkOutput("seq21_new", bus.new_isr, 1);
    checkOutput("seq21_jmp", bus.last_isr_jmp, 0);
    fetch(8'hC3);
    checkOutput("seqC3_new", bus.new_isr, 1);
    checkOutput("seqC3_jmp", bus.last_isr_jmp, 1);

    // DDCB d op: instruction ends at the CB fetch, then JP (HL)
    fetch(8'hDD);
    fetch(8'hCB);
    checkOutput("ddcb_new", bus.new_isr, 1);
    checkOutput("ddcb_jmp", bus.last_isr_jmp, 0);
    memRead(8'h05);
    memRead(8'hE9);
    checkOutput("ddcb_rd_new", bus.new_isr, 1);
    fetch(8'hE9);
    checkOutput("jphl_jmp", bus.last_isr_jmp, 1);
    fetch(8'hFD);
    checkOutput("fd_new", bus.new_isr, 0);
    checkOutput("fd_jmp_hold", bus.last_isr_jmp, 1);
    fetch(8'hE9);
    checkOutput("jpiy_new", bus.new_isr, 1);
    checkOutput("jpiy_jmp", bus.last_isr_jmp, 1);

    // Repeated index prefix keeps waiting for the real opcode
    fetch(8'hFD);
    fetch(8'hDD);
    checkOutput("fddd_new", bus.new_isr, 0);
    fetch(8'hE9);
    checkOutput("fddde9_jmp", bus.last_isr_jmp, 1);
    fetch(8'hCB);
    fetch(8'hE9);
    checkOutput("cbe9_new", bus.new_isr, 1);
    checkOutput("cbe9_jmp", bus.last_isr_jmp, 0);

    // Interrupt acknowledge in the middle of an ED instruction
    fetch(8'hC3);
    fetch(8'hED);
    checkOutput("ed_new", bus.new_isr, 0);
    checkOutput("ed_jmp", bus.last_isr_jmp, 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'hFF);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'hFF);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'hFF);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00);
    idleClk();
    checkOutput("intack_new", bus.new_isr, 0);
    checkOutput("intack_jmp", bus.last_isr_jmp, 1);
    checkOutput("intack_flag", bus.io_trap_condition, 0);
    fetch(8'h44);
    checkOutput("ed44_new", bus.new_isr, 1);
    checkOutput("ed44_jmp", bus.last_isr_jmp, 0);

    // Guest OUT to port 41 with zero mask and three wait states
    bus.virtual_enabled = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h41, 8'h12);
    checkOutput("out41_flag", bus.io_trap_condition, 1);
    checkOutput("out41_port", bus.trap_port, 16'h0041);
    checkOutput("out41_dir", bus.trap_dir, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h41, 8'h12);
    end
    idleClk();
    ioCycle(8'h80, 8'h00, 1'b0, 1);
    checkOutput("in80_flag", bus.io_trap_condition, 1);
    checkOutput("in80_port", bus.trap_port, 16'h0041);
    checkOutput("in80_dir", bus.trap_dir, 1);
    bus.trap_state = 1'b1;
    idleClk();
    checkOutput("clear_flag", bus.io_trap_condition, 0);

    // Handler context: I/O to an unpermitted port is not a violation
    ioCycle(8'h80, 8'h00, 1'b0, 0);
    checkOutput("host_in_flag", bus.io_trap_condition, 0);

    // Handler loads the mask; data changes on the wait clock are ignored
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3E, 8'h10);
    checkOutput("cfglo_mask", bus.permit_mask, 16'h0010);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3E, 8'h55);
    idleClk();
    checkOutput("cfglo_wait_mask", bus.permit_mask, 16'h0010);
    ioCycle(8'h3F, 8'h80, 1'b1, 2);
    checkOutput("cfghi_mask", bus.permit_mask, 16'h8010);

    // Guest reads against the loaded mask
    bus.trap_state = 1'b0;
    idleClk();
    ioCycle(8'h4F, 8'h00, 1'b0, 1);
    checkOutput("in4F_flag", bus.io_trap_condition, 0);
    ioCycle(8'h50, 8'h00, 1'b0, 1);
    checkOutput("in50_flag", bus.io_trap_condition, 1);
    checkOutput("in50_port", bus.trap_port, 16'h0050);
    checkOutput("in50_dir", bus.trap_dir, 0);
    bus.trap_state = 1'b1;
    idleClk();
    bus.trap_state = 1'b0;
    idleClk();
    checkOutput("clear2_flag", bus.io_trap_condition, 0);
    ioCycle(8'h3E, 8'hFF, 1'b1, 0);
    checkOutput("guestcfg_mask", bus.permit_mask, 16'h8010);
    checkOutput("guestcfg_flag", bus.io_trap_condition, 1);
    checkOutput("guestcfg_port", bus.trap_port, 16'h003E);
    checkOutput("guestcfg_dir", bus.trap_dir, 1);

    // Asynchronous reset in the middle of a CB-prefixed instruction
    fetch(8'hC3);
    fetch(8'hCB);
    checkOutput("precb_new", bus.new_isr, 0);
    checkOutput("precb_jmp", bus.last_isr_jmp, 1);
    checkOutput("precb_flag", bus.io_trap_condition, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_new", bus.new_isr, 1);
    checkOutput("arst_jmp", bus.last_isr_jmp, 0);
    checkOutput("arst_flag", bus.io_trap_condition, 0);
    checkOutput("arst_port", bus.trap_port, 0);
    checkOutput("arst_dir", bus.trap_dir, 0);
    checkOutput("arst_mask", bus.permit_mask, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    idleClk();
    fetch(8'hE9);
    checkOutput("post_rst_jmp", bus.last_isr_jmp, 1);
    checkOutput("post_rst_new", bus.new_isr, 1);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
